adc_spi_sampler: RTL and testbench

Free-running SPI master that continuously converts three channels of an external 10-bit SPI ADC (MCP300x-style command framing) and presents the upper 8 bits of each result as the `ADC0`/`ADC1`/`ADC2` bytes consumed by the CPU core's data-memory map. It sits directly upstream of the core: its byte outputs drive the core's ADC inputs unchanged, and the core reads them as memory-mapped registers.

---
 rtl/adc_spi_pkg.sv | 30 +++
 rtl/spi_phase_timer.sv | 27 ++
 rtl/adc_spi_sampler.sv | 146 ++++++++++++++
 tb/tb_adc_spi_sampler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared types, frame constants and command builder for the ADC sampler
package adc_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CLK_HI,
      CLK_LO,
      DONE,
      GAP
   } state_t;

   localparam int FRAME_BITS     = 16;
   localparam int DATA_FIRST_BIT = 6;
   localparam int DATA_LAST_BIT  = 13;
   localparam int NUM_CHANNELS   = 3;

   // Bit 0 is shifted out first: start, single-ended, then {0, ch} MSB first.
   function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [1:0] ch);
      logic [FRAME_BITS-1:0] w;
      w    = '0;
      w[0] = 1'b1;
      w[1] = 1'b1;
      w[2] = 1'b0;
      w[3] = ch[1];
      w[4] = ch[0];
      return w;
   endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - loadable down-counter timing SPI phases and the inter-frame gap
module spi_phase_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - free-running SPI master converting three ADC channels into byte registers
module adc_spi_sampler
   import adc_spi_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       spiMiso,
   output logic       spiSclk,
   output logic       spiMosi,
   output logic       spiCsN,
   output logic [7:0] ADC0,
   output logic [7:0] ADC1,
   output logic [7:0] ADC2,
   output logic       sampleValid,
   output logic [1:0] channel
);
   localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] DIV_LOAD  = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
   localparam logic [3:0]    FIRST_BIT = 4'(DATA_FIRST_BIT);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_LAST_BIT);
   localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);
   localparam logic [1:0]    LAST_CH   = 2'(NUM_CHANNELS - 1);

   state_t                state;
   state_t                state_next;
   logic [3:0]            bit_idx;
   logic [7:0]            capture;
   logic                  timer_load;
   logic                  timer_expired;
   logic [TW-1:0]         timer_value;
   logic                  frame_active;
   logic [FRAME_BITS-1:0] cmd;

   spi_phase_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .load_value(timer_value),
      .expired   (timer_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      timer_load  = 1'b0;
      timer_value = DIV_LOAD;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = SETUP;
               timer_load = 1'b1;
            end
         end
         SETUP: begin
            if (timer_expired) begin
               state_next = CLK_HI;
               timer_load = 1'b1;
            end
         end
         CLK_HI: begin
            if (timer_expired) begin
               state_next = (bit_idx == LAST_BIT) ? DONE : CLK_LO;
               timer_load = 1'b1;
            end
         end
         CLK_LO: begin
            if (timer_expired) begin
               state_next = CLK_HI;
               timer_load = 1'b1;
            end
         end
         DONE: begin
            state_next  = GAP;
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
         end
         GAP: begin
            if (timer_expired) begin
               state_next = enable ? SETUP : IDLE;
               timer_load = enable;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result bytes change only on the single DONE-entry edge, so a reader never sees a partial value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_idx <= 4'd0;
         capture <= 8'h00;
         ADC0    <= 8'h00;
         ADC1    <= 8'h00;
         ADC2    <= 8'h00;
         channel <= 2'd0;
      end else begin
         case (state)
            CLK_HI: begin
               if (timer_expired) begin
                  if (bit_idx >= FIRST_BIT && bit_idx <= LAST_DATA) begin
                     capture <= {capture[6:0], spiMiso};
                  end
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= 4'd0;
                     case (channel)
                        2'd0:    ADC0 <= capture;
                        2'd1:    ADC1 <= capture;
                        default: ADC2 <= capture;
                     endcase
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            DONE: begin
               channel <= (channel == LAST_CH) ? 2'd0 : channel + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign cmd          = cmd_word(channel);
   assign frame_active = (state == SETUP) || (state == CLK_HI) || (state == CLK_LO);
   assign spiCsN       = ~frame_active;
   assign spiSclk      = (state == CLK_HI);
   assign spiMosi      = frame_active & cmd[bit_idx];
   assign sampleValid  = (state == DONE);

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - self-checking bench for adc_spi_sampler with a behavioural ADC model
module tb_adc_spi_sampler;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       spiMiso;
   logic       spiSclk;
   logic       spiMosi;
   logic       spiCsN;
   logic [7:0] ADC0;
   logic [7:0] ADC1;
   logic [7:0] ADC2;
   logic       sampleValid;
   logic [1:0] channel;

   int checks   = 0;
   int failures = 0;

   adc_spi_sampler #(
      .CLK_DIV   (2),
      .GAP_CYCLES(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .spiMiso    (spiMiso),
      .spiSclk    (spiSclk),
      .spiMosi    (spiMosi),
      .spiCsN     (spiCsN),
      .ADC0       (ADC0),
      .ADC1       (ADC1),
      .ADC2       (ADC2),
      .sampleValid(sampleValid),
      .channel    (channel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ADC model: decodes the channel from MOSI on rising SCLK, drives data after each falling SCLK.
   logic [9:0]  adc_val [4];
   int          rises = 0;
   int          falls = 0;
   logic [15:0] mosi_word = 16'h0000;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;

   always @(spiCsN or spiSclk) begin
      if (prev_cs === 1'b1 && spiCsN === 1'b0) begin
         rises     = 0;
         falls     = 0;
         mosi_word = 16'h0000;
      end
      if (prev_sclk === 1'b0 && spiSclk === 1'b1) begin
         if (rises < 16) mosi_word[rises[3:0]] = spiMosi;
         rises++;
      end
      if (prev_sclk === 1'b1 && spiSclk === 1'b0 && spiCsN === 1'b0) falls++;
      prev_cs   = spiCsN;
      prev_sclk = spiSclk;
   end

   function automatic logic miso_bit(input int f, input logic [9:0] v);
      logic [9:0] sh;
      if (f < 6 || f > 15) return 1'b0;
      sh = v >> (15 - f);
      return sh[0];
   endfunction

   assign spiMiso = miso_bit(falls, adc_val[{mosi_word[3], mosi_word[4]}]);

   // Scoreboard: expected register contents and channel rotation, checked on every cycle.
   int         cycle = 0;
   int         cs_low_cnt = 0;
   logic [7:0] exp_adc [4];
   logic [1:0] model_ch = 2'd0;
   logic [1:0] dec;

   always @(negedge clk) begin
      cycle++;
      if (rst !== 1'b1) begin
         cs_low_cnt = 0;
         model_ch   = 2'd0;
         for (int i = 0; i < 4; i++) exp_adc[i] = 8'h00;
      end else begin
         if (spiCsN == 1'b0) cs_low_cnt++;
         if (sampleValid == 1'b1) begin
            dec = {mosi_word[3], mosi_word[4]};
            check("cs_low_cycles", cs_low_cnt, 64);
            check("sclk_rises", rises, 16);
            check("mosi_fixed_bits", {16'h0, mosi_word & 16'hFFE7}, 32'h0003);
            check("frame_channel", {30'h0, dec}, {30'h0, model_ch});
            check("channel_out", {30'h0, channel}, {30'h0, model_ch});
            exp_adc[dec] = adc_val[dec][9:2];
            model_ch     = (model_ch == 2'd2) ? 2'd0 : model_ch + 2'd1;
            cs_low_cnt   = 0;
         end
      end
      check("adc0_model", {24'h0, ADC0}, {24'h0, exp_adc[0]});
      check("adc1_model", {24'h0, ADC1}, {24'h0, exp_adc[1]});
      check("adc2_model", {24'h0, ADC2}, {24'h0, exp_adc[2]});
   end

   function automatic logic [7:0] read_adc(input logic [1:0] c);
      case (c)
         2'd0:    return ADC0;
         2'd1:    return ADC1;
         default: return ADC2;
      endcase
   endfunction

   task automatic wait_pulse(input int budget, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (sampleValid !== 1'b1 && n < budget);
      check(name, {31'h0, sampleValid}, 1);
   endtask

   task automatic wait_bit(input int k, input string name);
      int n;
      n = 0;
      while (!(spiCsN == 1'b0 && rises == k + 1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, rises, k + 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      int quiet;
      n     = 0;
      quiet = 0;
      while (quiet < 10 && n < 600) begin
         @(posedge clk);
         #1;
         n++;
         quiet = (spiCsN == 1'b1) ? quiet + 1 : 0;
      end
      check(name, quiet, 10);
   endtask

   typedef struct {
      logic [1:0]  ch;
      logic [7:0]  adc;
      logic [15:0] mosi;
      int          period;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int bad;
      int last_cyc;
      int nframes;

      vecs[0] = '{ch: 2'd0, adc: 8'hA9, mosi: 16'h0003, period: 0};
      vecs[1] = '{ch: 2'd1, adc: 8'hFF, mosi: 16'h0013, period: 69};
      vecs[2] = '{ch: 2'd2, adc: 8'h00, mosi: 16'h000B, period: 69};
      vecs[3] = '{ch: 2'd0, adc: 8'hA9, mosi: 16'h0003, period: 69};

      adc_val[0] = 10'h2A5;
      adc_val[1] = 10'h3FF;
      adc_val[2] = 10'h003;
      adc_val[3] = 10'h000;
      enable     = 1'b0;
      rst        = 1'b1;
      #1 rst     = 1'b0;
      #3;
      check("rst_csn", {31'h0, spiCsN}, 1);
      check("rst_sclk", {31'h0, spiSclk}, 0);
      check("rst_mosi", {31'h0, spiMosi}, 0);
      check("rst_valid", {31'h0, sampleValid}, 0);
      check("rst_channel", {30'h0, channel}, 0);
      check("rst_adc0", {24'h0, ADC0}, 0);
      check("rst_adc1", {24'h0, ADC1}, 0);
      check("rst_adc2", {24'h0, ADC2}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      bad = 0;
      repeat (200) begin
         @(posedge clk);
         #1;
         if (spiCsN !== 1'b1 || spiSclk !== 1'b0 || sampleValid !== 1'b0) bad++;
      end
      check("idle_quiet", bad, 0);

      enable   = 1'b1;
      last_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         wait_pulse(300, "table_pulse");
         check("table_channel", {30'h0, channel}, {30'h0, vecs[i].ch});
         check("table_adc", {24'h0, read_adc(vecs[i].ch)}, {24'h0, vecs[i].adc});
         check("table_mosi", {16'h0, mosi_word}, {16'h0, vecs[i].mosi});
         if (vecs[i].period != 0) check("table_period", cycle - last_cyc, vecs[i].period);
         last_cyc = cycle;
      end

      wait_bit(8, "drop_reach_bit8");
      enable = 1'b0;
      wait_pulse(300, "drop_pulse");
      check("drop_channel", {30'h0, channel}, 1);
      check("drop_adc1", {24'h0, ADC1}, 8'hFF);
      repeat (10) @(posedge clk);
      #1;
      check("drop_idle_csn", {31'h0, spiCsN}, 1);
      check("drop_idle_channel", {30'h0, channel}, 2);
      bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (spiCsN !== 1'b1) bad++;
      end
      check("drop_stays_idle", bad, 0);

      enable = 1'b1;
      wait_pulse(300, "pre_reset_pulse");
      check("pre_reset_channel", {30'h0, channel}, 2);
      wait_bit(10, "reset_reach_bit10");
      #2 rst = 1'b0;
      #1;
      check("async_rst_csn", {31'h0, spiCsN}, 1);
      check("async_rst_sclk", {31'h0, spiSclk}, 0);
      check("async_rst_adc0", {24'h0, ADC0}, 0);
      check("async_rst_adc1", {24'h0, ADC1}, 0);
      check("async_rst_adc2", {24'h0, ADC2}, 0);
      check("async_rst_channel", {30'h0, channel}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      wait_pulse(300, "post_reset_pulse");
      check("post_reset_channel", {30'h0, channel}, 0);
      check("post_reset_adc0", {24'h0, ADC0}, 8'hA9);
      check("post_reset_adc1", {24'h0, ADC1}, 0);
      check("post_reset_adc2", {24'h0, ADC2}, 0);

      enable = 1'b0;
      for (int it = 0; it < 6; it++) begin
         wait_idle("rand_idle");
         for (int c = 0; c < 3; c++) adc_val[c] = 10'($urandom_range(0, 1023));
         enable  = 1'b1;
         nframes = $urandom_range(1, 4);
         for (int k = 0; k < nframes; k++) wait_pulse(300, "rand_pulse");
         repeat ($urandom_range(0, 80)) @(posedge clk);
         #1 enable = 1'b0;
      end
      wait_idle("final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
